// File: rtl/bcd_to_binary_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD-to-binary converter.
// The same digit constants are used by the binary-to-BCD display converter.
package bcd_to_binary_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] CORR_SUB    = 4'd3;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] digit);
        return (digit > MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_to_binary_digit_sub3.sv
// One BCD digit correction step of reverse double dabble: digits >= 8 lose 3 (mod 16).
module bcd_to_binary_digit_sub3
    import bcd_to_binary_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= CORR_THRESH) ? (digit_in - CORR_SUB) : digit_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter, one result bit per clock with start/busy/done handshake.
// Optional digit range check (error port, invalid input skips conversion) under BCD2BIN_CHECK_EN.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     bcd_in,
    output logic                    busy,
    output logic                    done,
`ifdef BCD2BIN_CHECK_EN
    output logic                    error,
`endif
    output logic [BIN_W-1:0]        binary
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    shreg_q, shreg_d;
    logic [BIN_W-1:0]   binary_q, binary_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SR_W-1:0]    shifted_s;
    logic [SR_W-1:0]    corr_s;

    assign shifted_s             = shreg_q >> 1;
    assign corr_s[BIN_W-1:0]     = shifted_s[BIN_W-1:0];

    // Digit correction is applied to the already-shifted BCD field
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_to_binary_digit_sub3 u_sub3 (
            .digit_in  (shifted_s[BIN_W + DIGIT_W*g +: DIGIT_W]),
            .digit_out (corr_s[BIN_W + DIGIT_W*g +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic               error_q, error_d;
    logic [DIGITS-1:0]  digit_bad_s;
    logic               invalid_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_check
        assign digit_bad_s[g] = digit_invalid(bcd_in[DIGIT_W*g +: DIGIT_W]);
    end
    assign invalid_s = |digit_bad_s;
`endif

    // Next-state and next-output computation for the IDLE/SHIFT/DONE sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        binary_d = binary_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef BCD2BIN_CHECK_EN
        error_d  = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    shreg_d = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
`ifdef BCD2BIN_CHECK_EN
                    if (invalid_s) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        binary_d = '0;
                        error_d  = 1'b1;
                    end else begin
                        state_d  = ST_SHIFT;
                        busy_d   = 1'b1;
                        error_d  = 1'b0;
                    end
`else
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_d = corr_s;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    binary_d = corr_s[BIN_W-1:0];
                end else begin
                    state_d  = ST_SHIFT;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            binary_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            binary_q <= binary_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BCD2BIN_CHECK_EN
            error_q  <= error_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign binary = binary_q;
`ifdef BCD2BIN_CHECK_EN
    assign error  = error_q;
`endif

endmodule
